// File: rtl/vmac_pkg.sv
// vmac_pkg: op encodings and saturation/rounding helpers for vmac_array.
// Values travel through the helpers as exact MAXW-bit signed numbers. The
// result width is chosen by the w argument, so the helpers do not depend on
// module parameters.
package vmac_pkg;
   localparam int MAXW = 64;
   localparam logic [1:0] OP_MAC   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_MUL   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   // Clamp v to the w-bit signed or unsigned range. ovf reports whether
   // clamping happened.
   function automatic logic signed [MAXW-1:0] sat_acc(input logic signed [MAXW-1:0] v,
                                                      input int w, input logic sgn,
                                                      output logic ovf);
      logic signed [MAXW-1:0] hi, lo;
      hi  = (64'sd1 <<< (sgn ? w - 1 : w)) - 64'sd1;
      lo  = sgn ? -(64'sd1 <<< (w - 1)) : '0;
      ovf = v > hi || v < lo;
      return v > hi ? hi : v < lo ? lo : v;
   endfunction

   // Round half up, shift right by sh, then clamp to w bits.
   function automatic logic signed [MAXW-1:0] round_sat(input logic signed [MAXW-1:0] v,
                                                        input int sh, input int w,
                                                        input logic sgn);
      logic ovf_unused;
      return sat_acc(sh == 0 ? v : (v + (64'sd1 <<< (sh - 1))) >>> sh, w, sgn, ovf_unused);
   endfunction
endpackage

// File: rtl/vmac_lane.sv
// vmac_lane: one MAC lane. It holds the product register, the accumulator,
// the sticky overflow flag and the scaled result register.
//   clk, rst_n             clock, async active-low reset
//   in_valid, sgn, a, b    raw transaction inputs (product captured on in_valid)
//   s1_*                   shared stage-1 controls; the accumulator updates when s1_valid & s1_en
//   s2_valid, s2_signed    stage-2 controls; the result register loads from acc
//   clr_flags              clears ovf (a same-cycle set wins)
//   res, ovf               scaled result and sticky overflow flag
module vmac_lane import vmac_pkg::*; #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 36,
   parameter int FRAC_SHIFT = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic                  sgn,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  s1_valid,
   input  logic [1:0]            s1_op,
   input  logic                  s1_signed,
   input  logic                  s1_en,
   input  logic                  s2_valid,
   input  logic                  s2_signed,
   input  logic                  clr_flags,
   output logic [DATA_WIDTH-1:0] res,
   output logic                  ovf
);
   localparam int PW = 2 * DATA_WIDTH;
   logic [PW-1:0] prod_q, prod_u;
   logic signed [PW-1:0] prod_s;
   logic [DATA_WIDTH-1:0] rs2_q;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic signed [MAXW-1:0] acc_x, prod_x, load_x, sum;
   logic upd, sat_ovf;

   assign prod_s = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) * $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
   assign prod_u = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};

   // Operands are widened per the stage-1 signedness, so the accumulator bits
   // are reinterpreted rather than converted when signed_i changes.
   always_comb begin
      acc_x   = {{(MAXW-ACC_WIDTH){s1_signed & acc_q[ACC_WIDTH-1]}}, acc_q};
      prod_x  = {{(MAXW-PW){s1_signed & prod_q[PW-1]}}, prod_q};
      load_x  = {{(MAXW-DATA_WIDTH){s1_signed & rs2_q[DATA_WIDTH-1]}}, rs2_q} <<< FRAC_SHIFT;
      sum     = s1_op == OP_MAC ? acc_x + prod_x : s1_op == OP_LOAD ? load_x :
                s1_op == OP_MUL ? prod_x : '0;
      acc_d   = ACC_WIDTH'(sat_acc(sum, ACC_WIDTH, s1_signed, sat_ovf));
      upd     = s1_valid & s1_en;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         prod_q <= '0;
         rs2_q  <= '0;
         acc_q  <= '0;
         ovf    <= 1'b0;
         res    <= '0;
      end else begin
         if (in_valid) begin
            prod_q <= sgn ? prod_s : prod_u;
            rs2_q  <= b;
         end
         if (upd) acc_q <= acc_d;
         ovf <= (upd & sat_ovf) | (ovf & ~clr_flags & ~(upd & s1_op == OP_CLEAR));
         if (s2_valid)
            res <= DATA_WIDTH'(round_sat({{(MAXW-ACC_WIDTH){s2_signed & acc_q[ACC_WIDTH-1]}}, acc_q},
                                         FRAC_SHIFT, DATA_WIDTH, s2_signed));
      end
endmodule

// File: rtl/vmac_array.sv
// vmac_array: VMAX-lane vector multiply-accumulate with fixed-point output.
//   clk, rst_n             clock, async active-low reset
//   in_valid_i, op_i       transaction strobe and opcode (MAC/LOAD/MUL/CLEAR)
//   signed_i, lane_en_i    signedness and per-lane enable
//   rs1_i, rs2_i           packed operands, lane 0 in LSBs
//   clr_flags_i            clears all sticky overflow flags
//   out_valid_o            result strobe, two edges after the input strobe
//   vrd_data_o, ovf_o      packed scaled results and sticky overflow flags
module vmac_array import vmac_pkg::*; #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 36,
   parameter int VMAX       = 8,
   parameter int FRAC_SHIFT = 20
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid_i,
   input  logic [1:0]                 op_i,
   input  logic                       signed_i,
   input  logic [VMAX-1:0]            lane_en_i,
   input  logic [VMAX*DATA_WIDTH-1:0] rs1_i,
   input  logic [VMAX*DATA_WIDTH-1:0] rs2_i,
   input  logic                       clr_flags_i,
   output logic                       out_valid_o,
   output logic [VMAX*DATA_WIDTH-1:0] vrd_data_o,
   output logic [VMAX-1:0]            ovf_o
);
   logic v1, v2, s1_signed, s2_signed;
   logic [1:0] s1_op;
   logic [VMAX-1:0] s1_en;

   // v1: stage 1 holds a transaction; v2: accumulators were just updated.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v1          <= 1'b0;
         v2          <= 1'b0;
         out_valid_o <= 1'b0;
         s1_op       <= OP_MAC;
         s1_signed   <= 1'b0;
         s2_signed   <= 1'b0;
         s1_en       <= '0;
      end else begin
         v1          <= in_valid_i;
         v2          <= v1;
         out_valid_o <= v2;
         if (in_valid_i) begin
            s1_op     <= op_i;
            s1_signed <= signed_i;
            s1_en     <= lane_en_i;
         end
         if (v1) s2_signed <= s1_signed;
      end

   for (genvar i = 0; i < VMAX; i++) begin : g_lane
      vmac_lane #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH), .FRAC_SHIFT(FRAC_SHIFT)) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (in_valid_i),
         .sgn      (signed_i),
         .a        (rs1_i[i*DATA_WIDTH +: DATA_WIDTH]),
         .b        (rs2_i[i*DATA_WIDTH +: DATA_WIDTH]),
         .s1_valid (v1),
         .s1_op    (s1_op),
         .s1_signed(s1_signed),
         .s1_en    (s1_en[i]),
         .s2_valid (v2),
         .s2_signed(s2_signed),
         .clr_flags(clr_flags_i),
         .res      (vrd_data_o[i*DATA_WIDTH +: DATA_WIDTH]),
         .ovf      (ovf_o[i])
      );
   end
endmodule

// File: tb/tb_vmac_array.sv
// tb_vmac_array: directed self-checking bench for vmac_array.
module tb_vmac_array;
   import vmac_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0, in_valid_i = 1'b0, signed_i = 1'b0, clr_flags_i = 1'b0;
   logic [1:0] op_i = 2'b00;
   logic [7:0] lane_en_i = '0, ovf_o;
   logic [127:0] rs1_i = '0, rs2_i = '0, vrd_data_o;
   logic out_valid_o;
   int n_chk = 0, n_err = 0;

   vmac_array dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .op_i(op_i), .signed_i(signed_i),
      .lane_en_i(lane_en_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .clr_flags_i(clr_flags_i),
      .out_valid_o(out_valid_o), .vrd_data_o(vrd_data_o), .ovf_o(ovf_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic tx(input logic [1:0] op, input logic s, input logic [7:0] en,
                     input logic [15:0] a, input logic [15:0] b);
      in_valid_i = 1'b1; op_i = op; signed_i = s; lane_en_i = en;
      rs1_i = {8{a}}; rs2_i = {8{b}};
      idle();
      in_valid_i = 1'b0;
   endtask

   task automatic op1(input logic [1:0] op, input logic s, input logic [7:0] en,
                      input logic [15:0] a, input logic [15:0] b);
      tx(op, s, en, a, b);
      idle();
      idle();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) idle();
      check("rst_vld", {127'd0, out_valid_o}, 128'd0);
      check("rst_data", vrd_data_o, 128'd0);
      check("rst_ovf", {120'd0, ovf_o}, 128'd0);

      tx(OP_MUL, 1'b0, 8'hFF, 16'h4000, 16'h4000);
      tx(OP_MAC, 1'b0, 8'hFF, 16'h4000, 16'h4000);
      tx(OP_MAC, 1'b0, 8'hFF, 16'h4000, 16'h4000);
      check("u_vld1", {127'd0, out_valid_o}, 128'd1);
      check("u_res1", vrd_data_o, {8{16'h0100}});
      tx(OP_MAC, 1'b0, 8'hFF, 16'h4000, 16'h4000);
      check("u_res2", vrd_data_o, {8{16'h0200}});
      idle();
      check("u_res3", vrd_data_o, {8{16'h0300}});
      idle();
      check("u_vld4", {127'd0, out_valid_o}, 128'd1);
      check("u_res4", vrd_data_o, {8{16'h0400}});
      idle();
      check("u_vld_end", {127'd0, out_valid_o}, 128'd0);
      check("u_hold", vrd_data_o, {8{16'h0400}});

      op1(OP_LOAD, 1'b0, 8'h08, 16'h0000, 16'h1234);
      check("ld_res", vrd_data_o, {{4{16'h0400}}, 16'h1234, {3{16'h0400}}});
      op1(OP_MAC, 1'b0, 8'h08, 16'h0000, 16'h5555);
      check("ld_mac", vrd_data_o, {{4{16'h0400}}, 16'h1234, {3{16'h0400}}});

      tx(OP_MUL, 1'b1, 8'hFF, 16'h7FFF, 16'h7FFF);
      for (int i = 0; i < 31; i++) tx(OP_MAC, 1'b1, 8'hFF, 16'h7FFF, 16'h7FFF);
      idle();
      idle();
      check("s32_res", vrd_data_o, {8{16'h7FFE}});
      check("s32_ovf", {120'd0, ovf_o}, 128'd0);
      op1(OP_MAC, 1'b1, 8'hFF, 16'h7FFF, 16'h7FFF);
      check("s33_res", vrd_data_o, {8{16'h7FFF}});
      check("s33_ovf", {120'd0, ovf_o}, 128'hFF);
      clr_flags_i = 1'b1;
      idle();
      clr_flags_i = 1'b0;
      check("clrf_ovf", {120'd0, ovf_o}, 128'd0);
      op1(OP_MAC, 1'b1, 8'hFF, 16'h7FFF, 16'h7FFF);
      check("s34_ovf", {120'd0, ovf_o}, 128'hFF);
      op1(OP_CLEAR, 1'b1, 8'hFF, 16'h0000, 16'h0000);
      check("clr_res", vrd_data_o, 128'd0);
      check("clr_ovf", {120'd0, ovf_o}, 128'd0);

      op1(OP_MUL, 1'b1, 8'hFF, 16'h8000, 16'h0001);
      check("neg_mul", vrd_data_o, 128'd0);
      op1(OP_LOAD, 1'b1, 8'hFF, 16'h0000, 16'h8000);
      check("neg_load", vrd_data_o, {8{16'h8000}});

      tx(OP_MAC, 1'b1, 8'hFF, 16'h7FFF, 16'h7FFF);
      rst_n = 1'b0;
      check("mid_rst_vld", {127'd0, out_valid_o}, 128'd0);
      idle();
      rst_n = 1'b1;
      idle();
      check("post_rst_vld1", {127'd0, out_valid_o}, 128'd0);
      idle();
      check("post_rst_vld2", {127'd0, out_valid_o}, 128'd0);
      check("post_rst_data", vrd_data_o, 128'd0);
      check("post_rst_ovf", {120'd0, ovf_o}, 128'd0);
      op1(OP_MAC, 1'b0, 8'hFF, 16'h0000, 16'h0000);
      check("post_rst_acc", vrd_data_o, 128'd0);
      check("post_rst_mvld", {127'd0, out_valid_o}, 128'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
